uart_rx_param: RTL and testbench
================================

// Module: uart_rx_param
// PURPOSE
//  Parametrised UART receiver; next generation of the team's fixed 8N1 receiver.
//  Oversamples the serial line on an external baud tick and samples mid-bit.
//  Configurable data width, parity and stop bits; flags parity and framing errors.
//  Sits between the board RX pin and the byte consumer (ALU/interface logic).
// PARAMETERS
//  DATA_BITS   8   data bits per frame, 5..9, LSB first on the line
//  OVS         16  baud ticks per bit, even, >=4
//  PARITY_EN   0   1 = parity bit follows the data bits
//  PARITY_ODD  0   0 = even parity, 1 = odd (ignored if PARITY_EN=0)
//  STOP_BITS   1   number of stop bits, 1 or 2
// PORTS
//  i_clock      in   1          system clock, all logic on rising edge
//  i_reset      in   1          synchronous, active-high reset
//  i_tick       in   1          baud tick, 1-cycle pulse at OVS x baud rate
//  i_rx         in   1          asynchronous serial line, idle high
//  o_data       out  DATA_BITS  last received word, held until next o_valid
//  o_valid      out  1          1-cycle pulse: o_data and error flags updated
//  o_parity_err out  1          parity mismatch on last frame (0 if PARITY_EN=0)
//  o_frame_err  out  1          a stop bit sampled low on last frame
//  o_busy       out  1          high in every state except IDLE
// BEHAVIOUR
//  - i_rx passes through a 2-FF synchroniser (reset value 1); the FSM uses the
//    synchronised value only.
//  - Reset: FSM->IDLE, tick counter=0, bit counter=0, shift reg=0, o_data=0,
//    o_valid=0, both error flags=0. Reset mid-frame aborts the frame; no o_valid.
//  - Tick counter advances only on cycles with i_tick=1; no tick = no change.
//  - IDLE: on sync rx=0 -> START, tick counter cleared.
//  - START: on tick with counter=OVS/2-1, sample rx: 0 -> DATA (counter cleared,
//    bit counter cleared); 1 -> IDLE (glitch, no output).
//  - DATA: on tick with counter=OVS-1, sample rx, shift into MSB of the shift reg
//    (right shift), bit counter+1, counter cleared. After DATA_BITS samples ->
//    PARITY if PARITY_EN else STOP.
//  - PARITY: sample after OVS ticks; parity_err_next = (XOR of data ^ bit ^
//    PARITY_ODD) != 0 -> STOP.
//  - STOP: sample after OVS ticks per stop bit; STOP_BITS=2 samples twice.
//    frame_err_next = any stop sample = 0.
//  - After the final stop sample: next clock o_valid=1 for exactly one cycle,
//    o_data/o_parity_err/o_frame_err load together; FSM -> IDLE same cycle.
//  - Errored frames still pulse o_valid; the consumer decides on discard.
//  - Line still low after a framing error: IDLE re-arms at once, treating it as
//    a new start bit; a break yields repeated frame_err frames of 0.
//  - Outputs hold between o_valid pulses; no back-pressure, no buffering.
// TESTING (i_tick every 4 clocks, OVS=16, 8N1 unless stated)
//  1 Frame 0xA5 -> one o_valid pulse, o_data=0xA5, both errors 0, o_busy drops.
//  2 rx low for 4 ticks then high -> FSM back to IDLE, no o_valid, o_data held.
//  3 PARITY_EN=1 even, 0x37 with parity bit 1 -> parity_err=0; resend with
//    parity bit 0 -> parity_err=1, o_data=0x37.
//  4 0x5A with stop bit 0 -> o_valid pulses, o_frame_err=1; next good frame
//    0x11 -> frame_err=0.
//  5 i_reset after 3 data bits of 0xFF -> all outputs 0, no o_valid; next
//    frame 0x3C -> o_data=0x3C.
//  6 DATA_BITS=7, STOP_BITS=2, 0x55 back-to-back twice -> two pulses,
//    o_data=7'h55 each, no errors.

Source files
------------

// File: rtl/uart_rx_param.sv
// Parametrised oversampling UART receiver: 2-FF line synchroniser, mid-bit sampling,
// configurable data width, parity and stop bits, with parity/framing error flags.
module uart_rx_param #(
  parameter int DATA_BITS  = 8,
  parameter int OVS        = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_tick,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_busy
);

  localparam int TCW = $clog2(OVS);
  localparam int BCW = $clog2(DATA_BITS + 1);

  localparam logic [TCW-1:0] HALF_LAST = TCW'(OVS / 2 - 1);
  localparam logic [TCW-1:0] FULL_LAST = TCW'(OVS - 1);
  localparam logic [BCW-1:0] LAST_DATA = BCW'(DATA_BITS - 1);
  localparam logic [BCW-1:0] LAST_STOP = BCW'(STOP_BITS - 1);
  localparam logic           PAR_ODD   = (PARITY_ODD != 0);
  localparam logic           PAR_EN    = (PARITY_EN != 0);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic                 rx_meta_q, rx_sync_q;
  logic [2:0]           state_q, state_d;
  logic [TCW-1:0]       tick_cnt_q, tick_cnt_d;
  logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_err_q, par_err_d;
  logic                 frm_err_q, frm_err_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 parity_err_q, parity_err_d;
  logic                 frame_err_q, frame_err_d;
  logic                 frm_next;

  always_comb begin
    state_d      = state_q;
    tick_cnt_d   = tick_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    par_err_d    = par_err_q;
    frm_err_d    = frm_err_q;
    data_d       = data_q;
    valid_d      = 1'b0;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    frm_next     = frm_err_q | ~rx_sync_q;

    case (state_q)
      S_IDLE: begin
        if (!rx_sync_q) begin
          state_d    = S_START;
          tick_cnt_d = '0;
        end
      end
      S_START: begin
        if (i_tick) begin
          if (tick_cnt_q == HALF_LAST) begin
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
            par_err_d  = 1'b0;
            frm_err_d  = 1'b0;
            state_d    = rx_sync_q ? S_IDLE : S_DATA;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end
      S_DATA, S_PARITY, S_STOP: begin
        if (i_tick) begin
          if (tick_cnt_q != FULL_LAST) begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end else begin
            tick_cnt_d = '0;
            if (state_q == S_DATA) begin
              shift_d = {rx_sync_q, shift_q[DATA_BITS-1:1]};
              if (bit_cnt_q == LAST_DATA) begin
                bit_cnt_d = '0;
                state_d   = PAR_EN ? S_PARITY : S_STOP;
              end else begin
                bit_cnt_d = bit_cnt_q + 1'b1;
              end
            end else if (state_q == S_PARITY) begin
              par_err_d = (^shift_q) ^ rx_sync_q ^ PAR_ODD;
              bit_cnt_d = '0;
              state_d   = S_STOP;
            end else if (bit_cnt_q == LAST_STOP) begin
              // Final stop sample: publish the word and both flags together.
              state_d      = S_IDLE;
              valid_d      = 1'b1;
              data_d       = shift_q;
              parity_err_d = par_err_q;
              frame_err_d  = frm_next;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
              frm_err_d = frm_next;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      state_q      <= S_IDLE;
      tick_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_err_q    <= 1'b0;
      frm_err_q    <= 1'b0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      rx_meta_q    <= i_rx;
      rx_sync_q    <= rx_meta_q;
      state_q      <= state_d;
      tick_cnt_q   <= tick_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_err_q    <= par_err_d;
      frm_err_q    <= frm_err_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign o_data       = data_q;
  assign o_valid      = valid_q;
  assign o_parity_err = parity_err_q;
  assign o_frame_err  = frame_err_q;
  assign o_busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: three configurations (8N1, 8E1, 7N2) driven with
// directed frames; a queue-based scoreboard checks every o_valid pulse.
module tb_uart_rx_param;

  localparam int BIT = 64; // 16 ticks per bit, one tick every 4 clocks

  logic clk, rst, tick;
  logic rx0, rx1, rx2;

  logic [7:0] d0, d1;
  logic [6:0] d2;
  logic v0, v1, v2, pe0, pe1, pe2, fe0, fe1, fe2, b0, b1, b2;

  typedef struct {
    logic [8:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  exp_t q0[$], q1[$], q2[$];
  int checks = 0;
  int errors = 0;

  uart_rx_param #(.DATA_BITS(8), .OVS(16), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_8n1 (
    .i_clock(clk), .i_reset(rst), .i_tick(tick), .i_rx(rx0),
    .o_data(d0), .o_valid(v0), .o_parity_err(pe0), .o_frame_err(fe0), .o_busy(b0));

  uart_rx_param #(.DATA_BITS(8), .OVS(16), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_8e1 (
    .i_clock(clk), .i_reset(rst), .i_tick(tick), .i_rx(rx1),
    .o_data(d1), .o_valid(v1), .o_parity_err(pe1), .o_frame_err(fe1), .o_busy(b1));

  uart_rx_param #(.DATA_BITS(7), .OVS(16), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_7n2 (
    .i_clock(clk), .i_reset(rst), .i_tick(tick), .i_rx(rx2),
    .o_data(d2), .o_valid(v2), .o_parity_err(pe2), .o_frame_err(fe2), .o_busy(b2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    int n;
    n = 0;
    tick = 1'b0;
    forever begin
      @(negedge clk);
      tick = (n == 3);
      n = (n + 1) % 4;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic cmp_frame(input string nm, input exp_t e, input logic [8:0] d,
                           input logic pe, input logic fe);
    checks++;
    if (d !== e.data || pe !== e.perr || fe !== e.ferr) begin
      errors++;
      $display("FAIL %s: got data=0x%0h perr=%0b ferr=%0b expected data=0x%0h perr=%0b ferr=%0b",
               nm, d, pe, fe, e.data, e.perr, e.ferr);
    end
  endtask

  task automatic unexpected(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: o_valid with no frame expected", nm);
  endtask

  // Scoreboard monitors: sample on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst && v0) begin
      if (q0.size() == 0) unexpected("frame_8n1");
      else cmp_frame("frame_8n1", q0.pop_front(), {1'b0, d0}, pe0, fe0);
    end
    if (!rst && v1) begin
      if (q1.size() == 0) unexpected("frame_8e1");
      else cmp_frame("frame_8e1", q1.pop_front(), {1'b0, d1}, pe1, fe1);
    end
    if (!rst && v2) begin
      if (q2.size() == 0) unexpected("frame_7n2");
      else cmp_frame("frame_7n2", q2.pop_front(), {2'b0, d2}, pe2, fe2);
    end
  end

  task automatic push(input int d, input logic [8:0] data, input logic perr, input logic ferr);
    exp_t e;
    e.data = data;
    e.perr = perr;
    e.ferr = ferr;
    case (d)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic drive(input int d, input logic v, input int nclk);
    case (d)
      0: rx0 = v;
      1: rx1 = v;
      default: rx2 = v;
    endcase
    repeat (nclk) @(negedge clk);
  endtask

  // par < 0: no parity bit; otherwise par[0] is the parity bit sent.
  task automatic send(input int d, input logic [8:0] data, input int nbits, input int par,
                      input int nstop, input logic stopv, input int last_stop_len);
    drive(d, 1'b0, BIT);
    for (int i = 0; i < nbits; i++) drive(d, data[i], BIT);
    if (par >= 0) drive(d, par[0], BIT);
    for (int s = 0; s < nstop; s++) drive(d, stopv, (s == nstop - 1) ? last_stop_len : BIT);
  endtask

  initial begin
    rx0 = 1'b1; rx1 = 1'b1; rx2 = 1'b1;
    rst = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_data", {24'd0, d0}, 32'h0);
    chk("reset_flags", {29'd0, v0, pe0, fe0}, 32'h0);
    chk("reset_busy", {31'd0, b0}, 32'h0);

    // Clean 8N1 frame
    push(0, 9'h0A5, 1'b0, 1'b0);
    send(0, 9'h0A5, 8, -1, 1, 1'b1, BIT);
    drive(0, 1'b1, 2 * BIT);
    chk("idle_busy_after_a5", {31'd0, b0}, 32'h0);

    // Start-bit glitch: 4 ticks low, then high
    drive(0, 1'b0, 12);
    chk("glitch_busy_high", {31'd0, b0}, 32'h1);
    drive(0, 1'b0, 4);
    drive(0, 1'b1, 2 * BIT);
    chk("glitch_busy_low", {31'd0, b0}, 32'h0);
    chk("glitch_data_held", {24'd0, d0}, 32'hA5);

    // Even parity: 0x37 has five ones, so the correct parity bit is 1
    push(1, 9'h037, 1'b0, 1'b0);
    send(1, 9'h037, 8, 1, 1, 1'b1, BIT);
    drive(1, 1'b1, 2 * BIT);
    push(1, 9'h037, 1'b1, 1'b0);
    send(1, 9'h037, 8, 0, 1, 1'b1, BIT);
    drive(1, 1'b1, 2 * BIT);

    // Low stop bit; released shortly after its sample so the re-armed start is a glitch
    push(0, 9'h05A, 1'b0, 1'b1);
    send(0, 9'h05A, 8, -1, 1, 1'b0, 40);
    drive(0, 1'b1, 3 * BIT);
    push(0, 9'h011, 1'b0, 1'b0);
    send(0, 9'h011, 8, -1, 1, 1'b1, BIT);
    drive(0, 1'b1, 2 * BIT);

    // Reset after start + 3 data bits of 0xFF aborts the frame
    drive(0, 1'b0, BIT);
    drive(0, 1'b1, 3 * BIT);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midreset_data", {24'd0, d0}, 32'h0);
    chk("midreset_flags", {29'd0, v0, pe0, fe0}, 32'h0);
    chk("midreset_busy", {31'd0, b0}, 32'h0);
    drive(0, 1'b1, 10 * BIT);
    push(0, 9'h03C, 1'b0, 1'b0);
    send(0, 9'h03C, 8, -1, 1, 1'b1, BIT);
    drive(0, 1'b1, 2 * BIT);

    // 7N2, two frames back to back
    push(2, 9'h055, 1'b0, 1'b0);
    push(2, 9'h055, 1'b0, 1'b0);
    send(2, 9'h055, 7, -1, 2, 1'b1, BIT);
    send(2, 9'h055, 7, -1, 2, 1'b1, BIT);
    drive(2, 1'b1, 3 * BIT);

    chk("pending_8n1", q0.size(), 32'd0);
    chk("pending_8e1", q1.size(), 32'd0);
    chk("pending_7n2", q2.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
